// File: rtl/fetch_stage.sv
// RV32I instruction fetch: PC register, imem address drive and IF/ID register.
// Optional FETCH_MISALIGN_TRAP_EN halts fetch on a misaligned redirect target.
module fetch_stage #(
   parameter int unsigned           DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
   parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  redirect,
   input  logic [DATA_WIDTH-1:0] redirect_target,
   output logic [DATA_WIDTH-1:0] imem_addr,
   input  logic [DATA_WIDTH-1:0] imem_data,
   output logic [DATA_WIDTH-1:0] instr_d,
   output logic [DATA_WIDTH-1:0] pc_d,
   output logic [DATA_WIDTH-1:0] pc_plus4_d,
   output logic                  valid_d,
   output logic [31:0]           fetch_count,
   output logic                  misalign_err
);

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } state_t;

   state_t                state;
   logic [DATA_WIDTH-1:0] pc_f;
   logic [DATA_WIDTH-1:0] pc_next;
   logic [DATA_WIDTH-1:0] target;
   logic                  bad_target;

   assign imem_addr = pc_f;
   assign pc_next   = pc_f + DATA_WIDTH'(4);

`ifdef FETCH_MISALIGN_TRAP_EN
   logic misalign_q;

   assign target       = redirect_target;
   assign bad_target   = redirect_target[1:0] != 2'b00;
   assign misalign_err = misalign_q;
`else
   logic unused_low_bits;

   // Low target bits are dropped so the PC always stays word aligned.
   assign target          = {redirect_target[DATA_WIDTH-1:2], 2'b00};
   assign bad_target      = 1'b0;
   assign misalign_err    = 1'b0;
   assign unused_low_bits = ^redirect_target[1:0];
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= RUN;
         pc_f        <= RESET_PC;
         instr_d     <= NOP_INSTR;
         pc_d        <= '0;
         pc_plus4_d  <= '0;
         valid_d     <= 1'b0;
         fetch_count <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
         misalign_q  <= 1'b0;
`endif
      end else begin
         unique case (state)
            RUN: begin
               if (redirect) begin
                  if (bad_target) begin
                     state <= HALT;
`ifdef FETCH_MISALIGN_TRAP_EN
                     misalign_q <= 1'b1;
`endif
                  end else begin
                     pc_f <= target;
                  end
                  instr_d    <= NOP_INSTR;
                  pc_d       <= '0;
                  pc_plus4_d <= '0;
                  valid_d    <= 1'b0;
               end else if (stall) begin
                  if (flush) begin
                     instr_d    <= NOP_INSTR;
                     pc_d       <= '0;
                     pc_plus4_d <= '0;
                     valid_d    <= 1'b0;
                  end
               end else if (flush) begin
                  pc_f       <= pc_next;
                  instr_d    <= NOP_INSTR;
                  pc_d       <= '0;
                  pc_plus4_d <= '0;
                  valid_d    <= 1'b0;
               end else begin
                  pc_f        <= pc_next;
                  instr_d     <= imem_data;
                  pc_d        <= pc_f;
                  pc_plus4_d  <= pc_next;
                  valid_d     <= 1'b1;
                  fetch_count <= fetch_count + 32'd1;
               end
            end
            HALT: begin
               valid_d <= 1'b0;
            end
            default: begin
               state <= RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: random stall/flush/redirect traffic
// checked against a PC/IF-ID reference model.
module tb_fetch_stage;

`ifdef FETCH_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_target = '0;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic [31:0] instr_d;
   logic [31:0] pc_d;
   logic [31:0] pc_plus4_d;
   logic        valid_d;
   logic [31:0] fetch_count;
   logic        misalign_err;

   fetch_stage dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .flush           (flush),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .imem_addr       (imem_addr),
      .imem_data       (imem_data),
      .instr_d         (instr_d),
      .pc_d            (pc_d),
      .pc_plus4_d      (pc_plus4_d),
      .valid_d         (valid_d),
      .fetch_count     (fetch_count),
      .misalign_err    (misalign_err)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem(input logic [31:0] a);
      if (a == 32'h0) return 32'h0050_0093;
      if (a == 32'h4) return 32'h0010_0113;
      return {a[15:0], ~a[31:16]} ^ 32'h0013_0013;
   endfunction

   assign imem_data = mem(imem_addr);

   typedef struct {
      logic [31:0] addr;
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc4;
      logic [31:0] cnt;
      logic        valid;
      logic        err;
   } exp_t;

   exp_t q[$];

   // Reference model state
   logic [31:0] m_pc, m_instr, m_pcd, m_pc4, m_cnt;
   logic        m_valid, m_err, m_halt;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0t got %h expected %h", nm, $time, act, exp);
      end
   endtask

   task automatic m_reset();
      m_pc = 32'h0; m_instr = NOP; m_pcd = 0; m_pc4 = 0;
      m_cnt = 0; m_valid = 0; m_err = 0; m_halt = 0;
   endtask

   task automatic m_bubble();
      m_instr = NOP; m_pcd = 0; m_pc4 = 0; m_valid = 0;
   endtask

   task automatic model(input logic s, f, r, input logic [31:0] t);
      if (m_halt) begin
         m_valid = 0;
      end else if (r) begin
         if (TRAP && t[1:0] != 2'b00) begin
            m_err = 1; m_halt = 1;
         end else begin
            m_pc = t & 32'hFFFF_FFFC;
         end
         m_bubble();
      end else if (s) begin
         if (f) m_bubble();
      end else if (f) begin
         m_pc = m_pc + 4;
         m_bubble();
      end else begin
         m_instr = mem(m_pc);
         m_pcd   = m_pc;
         m_pc4   = m_pc + 4;
         m_valid = 1;
         m_cnt   = m_cnt + 1;
         m_pc    = m_pc + 4;
      end
   endtask

   task automatic push();
      exp_t e;
      e.addr = m_pc; e.instr = m_instr; e.pc = m_pcd; e.pc4 = m_pc4;
      e.cnt = m_cnt; e.valid = m_valid; e.err = m_err;
      q.push_back(e);
   endtask

   task automatic step(input logic s, f, r, input logic [31:0] t);
      stall = s; flush = f; redirect = r; redirect_target = t;
      @(posedge clk);
      model(s, f, r, t);
      push();
      @(negedge clk);
      #1;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".imem_addr"}, imem_addr, 32'h0);
      chk({tag, ".instr_d"}, instr_d, NOP);
      chk({tag, ".pc_d"}, pc_d, 32'h0);
      chk({tag, ".pc_plus4_d"}, pc_plus4_d, 32'h0);
      chk({tag, ".valid_d"}, {31'b0, valid_d}, 32'h0);
      chk({tag, ".fetch_count"}, fetch_count, 32'h0);
      chk({tag, ".misalign_err"}, {31'b0, misalign_err}, 32'h0);
   endtask

   // Monitor: one expected IF/ID snapshot per stimulus edge
   always @(negedge clk) begin
      if (q.size() != 0) begin
         exp_t e;
         e = q.pop_front();
         chk("imem_addr", imem_addr, e.addr);
         chk("instr_d", instr_d, e.instr);
         chk("pc_d", pc_d, e.pc);
         chk("pc_plus4_d", pc_plus4_d, e.pc4);
         chk("valid_d", {31'b0, valid_d}, {31'b0, e.valid});
         chk("fetch_count", fetch_count, e.cnt);
         chk("misalign_err", {31'b0, misalign_err}, {31'b0, e.err});
      end
   end

   initial begin
      m_reset();
      @(posedge clk);
      #2;
      chk_reset("reset");
      @(negedge clk);
      rst = 1'b0;
      #1;

      // Free run, stall at 0x8, resume
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      repeat (3) step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);

      // Redirect overrides stall
      step(1, 0, 1, 32'h40);
      step(0, 0, 0, 0);

      // Flush with and without stall
      step(1, 1, 0, 0);
      step(0, 1, 0, 0);
      step(0, 0, 0, 0);

      // PC wrap at the top of the address space
      step(0, 0, 1, 32'hFFFF_FFFC);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);

      for (int i = 0; i < 300; i++) begin
         logic        s, f, r;
         logic [31:0] t;
         s = ($urandom_range(0, 3) == 0);
         f = ($urandom_range(0, 5) == 0);
         r = ($urandom_range(0, 7) == 0);
         t = $urandom;
         if (TRAP) t[1:0] = 2'b00;
         step(s, f, r, t);
      end

      // Asynchronous reset in the middle of a stall
      step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      stall = 1'b1;
      rst = 1'b1;
      #1;
      chk_reset("async_rst");
      m_reset();
      @(negedge clk);
      rst = 1'b0;
      stall = 1'b0;
      #1;
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);

      // Misaligned redirect target
      step(0, 0, 1, 32'h42);
      repeat (5) step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 1) == 1, 32'h80);
      step(0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk_reset("halt_rst");
      m_reset();
      @(negedge clk);
      rst = 1'b0;
      #1;
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);

      @(negedge clk);
      #1;
      chk("scoreboard_drained", q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the RV32I core. Holds the program counter, drives the byte address into the combinational instruction memory, and registers the returned 32-bit instruction with its PC into the IF/ID pipeline register consumed by decode. Supports stall, flush and branch/jump redirect from later stages, and keeps a count of instructions delivered.

## Interface
- DATA_WIDTH, 32, width of PC, addresses and instruction words
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_INSTR, 32'h0000_0013, instruction word placed in IF/ID when empty (addi x0,x0,0)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- stall  in  1  hold PC and IF/ID contents this cycle
- flush  in  1  invalidate IF/ID contents this cycle
- redirect  in  1  load PC from redirect_target (taken branch/jump)
- redirect_target  in  DATA_WIDTH  new PC on redirect
- imem_addr  out  DATA_WIDTH  byte address to instruction memory (= pc_f)
- imem_data  in  DATA_WIDTH  instruction word from memory, same cycle as imem_addr
- instr_d  out  DATA_WIDTH  registered instruction to decode
- pc_d  out  DATA_WIDTH  registered PC of instr_d
- pc_plus4_d  out  DATA_WIDTH  registered pc_d + 4
- valid_d  out  1  instr_d is a real fetched instruction
- fetch_count  out  32  number of instructions written into IF/ID with valid_d=1
- misalign_err  out  1  sticky misaligned-redirect flag (see Configuration)

## Operation
- State machine: RUN, HALT. Reset → RUN. HALT only reachable with FETCH_MISALIGN_TRAP_EN.
- pc_f internal register; imem_addr = pc_f combinationally. Memory read assumed combinational; imem_data valid in the same cycle.
- RUN, per rising edge, priority order:
  - redirect=1: pc_f ← redirect_target; IF/ID ← {NOP_INSTR, pc 0, pc+4 0, valid 0}. Overrides stall and flush.
  - else stall=1: pc_f holds. IF/ID holds, unless flush=1, in which case IF/ID is cleared to NOP/valid 0.
  - else flush=1: pc_f ← pc_f+4; IF/ID cleared to NOP/valid 0 (fetched word discarded).
  - else: pc_f ← pc_f+4; instr_d ← imem_data; pc_d ← pc_f; pc_plus4_d ← pc_f+4; valid_d ← 1; fetch_count += 1.
- HALT: pc_f, IF/ID hold; valid_d forced 0; all inputs ignored until rst.
- Arithmetic: pc_f+4 modulo 2^DATA_WIDTH (0xFFFF_FFFC → 0x0000_0000). fetch_count wraps 0xFFFF_FFFF → 0.
- fetch_count increments only on the plain-advance branch; never on stall, flush or redirect cycles.

## Timing
- Reset (asynchronous, immediate): pc_f=RESET_PC, imem_addr=RESET_PC, instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0, valid_d=0, fetch_count=0, misalign_err=0, state RUN.
- Reset mid-operation discards IF/ID contents and any pending redirect; first fetch after release at RESET_PC.
- Fetch latency: instruction at address A appears on instr_d one cycle after imem_addr=A with no stall.
- Redirect penalty: redirect sampled at edge N → imem_addr=target after edge N; instr_d at target valid after edge N+1; one bubble (valid_d=0) between.
- Stall is level-sensitive; held N cycles, outputs stable N cycles, no instruction lost or duplicated.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined: redirect with redirect_target[1:0] != 2'b00 does not load pc_f; IF/ID cleared; misalign_err ← 1 (sticky); state → HALT until rst.
- Undefined: redirect_target[1:0] ignored, pc_f ← {redirect_target[DATA_WIDTH-1:2], 2'b00}; misalign_err tied 0; HALT unreachable.

## Test plan
- Reset then 4 free-running cycles, imem returns 0x00500093 at 0, 0x00100113 at 4 → instr_d/pc_d sequence 0x00500093/0, 0x00100113/4; valid_d=1; fetch_count=4 after fourth edge.
- stall high 3 cycles at pc_f=0x8 → imem_addr stays 0x8, instr_d/pc_d unchanged, fetch_count unchanged; resume fetches 0x8 exactly once.
- redirect=1, target 0x40, concurrent stall=1 → next cycle imem_addr=0x40, valid_d=0; following cycle pc_d=0x40, valid_d=1.
- flush=1 with stall=1 → pc_f holds, instr_d=0x00000013, valid_d=0; flush alone → pc_f advances by 4, valid_d=0.
- pc_f=0xFFFF_FFFC advance → pc_plus4_d=0x0, next imem_addr=0x0; rst asserted mid-stall → outputs to reset values immediately, without waiting for clk.
- Misaligned target 0x42: with FETCH_MISALIGN_TRAP_EN → misalign_err=1, imem_addr frozen, valid_d=0 until rst; without → imem_addr=0x40, misalign_err=0.
